// File: rtl/fp_adder_align_stage_if.sv
// Handshake and data bundle for the floating-point adder alignment stage.
// The slave side belongs to the stage itself; the master side drives operands and consumes results.
interface fp_adder_align_stage_if #(
    parameter int EXPONENT_WIDTH    = 8,
    parameter int SIGNIFICAND_WIDTH = 23,
    parameter int LANES             = 1
);
    localparam int TOTAL_WIDTH = 1 + EXPONENT_WIDTH + SIGNIFICAND_WIDTH;
    localparam int SW          = SIGNIFICAND_WIDTH + 3;
    localparam int SHW         = $clog2(SW + 1);

    logic                               in_valid;
    logic                               in_ready;
    logic                               is_subtract;
    logic [LANES*TOTAL_WIDTH-1:0]       operand1;
    logic [LANES*TOTAL_WIDTH-1:0]       operand2;
    logic                               out_valid;
    logic                               out_ready;
    logic [LANES*SHW-1:0]               align_shift;
    logic [LANES*SW-1:0]                significand1;
    logic [LANES*SW-1:0]                significand2;
    logic [LANES*EXPONENT_WIDTH-1:0]    exponent_larger;
    logic [LANES-1:0]                   result_is_inf;
    logic [LANES-1:0]                   result_is_nan;
    logic [LANES-1:0]                   result_inf_sign;

    modport master (
        output in_valid, is_subtract, operand1, operand2, out_ready,
        input  in_ready, out_valid, align_shift, significand1, significand2,
               exponent_larger, result_is_inf, result_is_nan, result_inf_sign
    );

    modport slave (
        input  in_valid, is_subtract, operand1, operand2, out_ready,
        output in_ready, out_valid, align_shift, significand1, significand2,
               exponent_larger, result_is_inf, result_is_nan, result_inf_sign
    );
endinterface

// File: rtl/fp_adder_align_stage.sv
// Alignment stage of a multi-lane FP adder: unpacks operands, orders them by exponent,
// converts significands to two's complement and flags inf/NaN, behind a registered skid buffer.
module fp_adder_align_stage #(
    parameter int EXPONENT_WIDTH    = 8,
    parameter int SIGNIFICAND_WIDTH = 23,
    parameter int LANES             = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    fp_adder_align_stage_if.slave bus
);
    localparam int EW          = EXPONENT_WIDTH;
    localparam int FW          = SIGNIFICAND_WIDTH;
    localparam int TOTAL_WIDTH = 1 + EW + FW;
    localparam int SW          = FW + 3;
    localparam int SHW         = $clog2(SW + 1);
    localparam int CW          = ((EW > SHW) ? EW : SHW) + 1;

    typedef struct packed {
        logic [SHW-1:0] shift;
        logic [SW-1:0]  sig1;
        logic [SW-1:0]  sig2;
        logic [EW-1:0]  exp_larger;
        logic           is_inf;
        logic           is_nan;
        logic           inf_sign;
    } lane_t;

    lane_t [LANES-1:0] next_data;
    lane_t [LANES-1:0] out_data;
    lane_t [LANES-1:0] skid_data;
    logic              out_valid;
    logic              skid_valid;
    logic              accept;
    logic              drain;

    genvar l;
    for (l = 0; l < LANES; l++) begin : g_lane
        logic [TOTAL_WIDTH-1:0] op_a;
        logic [TOTAL_WIDTH-1:0] op_b;
        logic                   sign_a;
        logic                   sign_b;
        logic [EW-1:0]          exp_a;
        logic [EW-1:0]          exp_b;
        logic [FW-1:0]          frac_a;
        logic [FW-1:0]          frac_b;
        logic [EW-1:0]          eff_a;
        logic [EW-1:0]          eff_b;
        logic [SW-1:0]          mag_a;
        logic [SW-1:0]          mag_b;
        logic [SW-1:0]          sig_a;
        logic [SW-1:0]          sig_b;
        logic                   swap;
        logic [EW-1:0]          diff;
        logic [CW-1:0]          diff_ext;
        logic                   max_a;
        logic                   max_b;
        logic                   inf_a;
        logic                   inf_b;
        logic                   nan_a;
        logic                   nan_b;
        logic                   nan_any;
        lane_t                  res;

        assign op_a   = bus.operand1[l*TOTAL_WIDTH +: TOTAL_WIDTH];
        assign op_b   = bus.operand2[l*TOTAL_WIDTH +: TOTAL_WIDTH];
        assign sign_a = op_a[TOTAL_WIDTH-1];
        // Subtraction is folded into the effective sign of the second operand.
        assign sign_b = op_b[TOTAL_WIDTH-1] ^ bus.is_subtract;
        assign exp_a  = op_a[TOTAL_WIDTH-2 -: EW];
        assign exp_b  = op_b[TOTAL_WIDTH-2 -: EW];
        assign frac_a = op_a[FW-1:0];
        assign frac_b = op_b[FW-1:0];

        // Subnormals share the scale of exponent 1, just without the hidden bit.
        assign eff_a  = (exp_a == '0) ? EW'(1) : exp_a;
        assign eff_b  = (exp_b == '0) ? EW'(1) : exp_b;
        assign mag_a  = {2'b00, |exp_a, frac_a};
        assign mag_b  = {2'b00, |exp_b, frac_b};
        assign sig_a  = sign_a ? (~mag_a + SW'(1)) : mag_a;
        assign sig_b  = sign_b ? (~mag_b + SW'(1)) : mag_b;

        assign swap     = eff_b > eff_a;
        assign diff     = swap ? (eff_b - eff_a) : (eff_a - eff_b);
        assign diff_ext = CW'(diff);

        assign max_a   = &exp_a;
        assign max_b   = &exp_b;
        assign inf_a   = max_a & ~(|frac_a);
        assign inf_b   = max_b & ~(|frac_b);
        assign nan_a   = max_a & (|frac_a);
        assign nan_b   = max_b & (|frac_b);
        assign nan_any = nan_a | nan_b | (inf_a & inf_b & (sign_a ^ sign_b));

        // Shifting past the full significand width gives the same result, so clamp there.
        assign res.shift      = (diff_ext > CW'(SW)) ? SHW'(SW) : diff_ext[SHW-1:0];
        assign res.sig1       = swap ? sig_b : sig_a;
        assign res.sig2       = swap ? sig_a : sig_b;
        assign res.exp_larger = swap ? eff_b : eff_a;
        assign res.is_nan     = nan_any;
        assign res.is_inf     = ~nan_any & (inf_a | inf_b);
        assign res.inf_sign   = ~nan_any & (inf_a ? sign_a : (inf_b & sign_b));

        assign next_data[l] = res;

        assign bus.align_shift[l*SHW +: SHW]   = out_data[l].shift;
        assign bus.significand1[l*SW +: SW]    = out_data[l].sig1;
        assign bus.significand2[l*SW +: SW]    = out_data[l].sig2;
        assign bus.exponent_larger[l*EW +: EW] = out_data[l].exp_larger;
        assign bus.result_is_inf[l]            = out_data[l].is_inf;
        assign bus.result_is_nan[l]            = out_data[l].is_nan;
        assign bus.result_inf_sign[l]          = out_data[l].inf_sign;
    end

    // Ready depends only on the skid flag, so no combinational path runs from out_ready.
    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = out_valid;
    assign accept        = bus.in_valid & ~skid_valid;
    assign drain         = out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (drain || !out_valid) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= next_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= next_data;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_adder_align_stage.sv
// Scoreboard bench for fp_adder_align_stage with four lanes: directed IEEE cases on every lane,
// backpressure through the skid buffer, random operands and reset during a stall.
module tb_fp_adder_align_stage;
    localparam int EW    = 8;
    localparam int FW    = 23;
    localparam int LANES = 4;
    localparam int TW    = 32;
    localparam int SW    = 26;
    localparam int SHW   = 5;

    typedef struct packed {
        logic [LANES*SHW-1:0] shift;
        logic [LANES*SW-1:0]  s1;
        logic [LANES*SW-1:0]  s2;
        logic [LANES*EW-1:0]  e;
        logic [LANES-1:0]     inf;
        logic [LANES-1:0]     nan;
        logic [LANES-1:0]     isg;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_adder_align_stage_if #(.EXPONENT_WIDTH(EW), .SIGNIFICAND_WIDTH(FW), .LANES(LANES)) bus ();

    fp_adder_align_stage #(.EXPONENT_WIDTH(EW), .SIGNIFICAND_WIDTH(FW), .LANES(LANES)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic out_t model(input logic [LANES*TW-1:0] op1, input logic [LANES*TW-1:0] op2,
                                   input logic sub);
        out_t r = '0;
        for (int l = 0; l < LANES; l++) begin
            logic [31:0] a = op1[l*TW +: TW];
            logic [31:0] b = op2[l*TW +: TW];
            int ea = int'(a[30:23]);
            int eb = int'(b[30:23]);
            int fa = int'(a[22:0]);
            int fb = int'(b[22:0]);
            int effa = (ea == 0) ? 1 : ea;
            int effb = (eb == 0) ? 1 : eb;
            int ma = ((ea != 0) ? (1 << 23) : 0) + fa;
            int mb = ((eb != 0) ? (1 << 23) : 0) + fb;
            bit na = a[31];
            bit nb = b[31] ^ sub;
            int va = na ? ((1 << 26) - ma) % (1 << 26) : ma;
            int vb = nb ? ((1 << 26) - mb) % (1 << 26) : mb;
            int d = (effa > effb) ? effa - effb : effb - effa;
            bit infa = (ea == 255) && (fa == 0);
            bit infb = (eb == 255) && (fb == 0);
            bit nana = (ea == 255) && (fa != 0);
            bit nanb = (eb == 255) && (fb != 0);
            bit nan = nana || nanb || (infa && infb && (na != nb));
            bit inf = !nan && (infa || infb);
            r.shift[l*SHW +: SHW] = 5'((d > 26) ? 26 : d);
            if (effb > effa) begin
                r.s1[l*SW +: SW] = 26'(vb);
                r.s2[l*SW +: SW] = 26'(va);
                r.e[l*EW +: EW]  = 8'(effb);
            end else begin
                r.s1[l*SW +: SW] = 26'(va);
                r.s2[l*SW +: SW] = 26'(vb);
                r.e[l*EW +: EW]  = 8'(effa);
            end
            r.nan[l] = nan;
            r.inf[l] = inf;
            r.isg[l] = inf && (infa ? na : nb);
        end
        return r;
    endfunction

    function automatic out_t observed();
        out_t r;
        r.shift = bus.align_shift;
        r.s1    = bus.significand1;
        r.s2    = bus.significand2;
        r.e     = bus.exponent_larger;
        r.inf   = bus.result_is_inf;
        r.nan   = bus.result_is_nan;
        r.isg   = bus.result_inf_sign;
        return r;
    endfunction

    function automatic logic [31:0] randOp();
        logic [31:0] v = $urandom;
        case ($urandom_range(0, 7))
            0: v[30:23] = 8'd0;
            1: v[30:23] = 8'd255;
            2: v[30:23] = 8'd254;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) v[22:0] = '0;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [LANES*TW-1:0] op1, input logic [LANES*TW-1:0] op2,
                                 input logic sub, input bit rand_ready);
        out_t e = model(op1, op2, sub);
        logic rdy = 1'b0;
        bus.operand1    = op1;
        bus.operand2    = op2;
        bus.is_subtract = sub;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            if (rdy) begin
                exp_q.push_back(e);
                return;
            end
        end
        checks++;
        assert (rdy)
        else begin
            errors++;
            $error("[TB] FAIL accept_timeout observed=%0b expected=1", rdy);
        end
    endtask

    // Pops the scoreboard for every output transfer that the coming rising edge will complete.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            checks++;
            assert (exp_q.size() > 0)
            else begin
                errors++;
                $error("[TB] FAIL unexpected_output observed=%0h expected=none", observed());
            end
            if (exp_q.size() > 0) checkOutput("scoreboard", 512'(observed()), 512'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [LANES*TW-1:0] opA, opB, opC;
        $display("[TB] start");
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.is_subtract = 1'b0;
        bus.operand1    = '0;
        bus.operand2    = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 512'(bus.in_ready), 512'(1));
        checkOutput("reset_out_valid", 512'(bus.out_valid), 512'(0));
        checkOutput("reset_data", 512'(observed()), 512'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus({4{32'h3F800000}}, {4{32'h40000000}}, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        checkOutput("one_two_valid", 512'(bus.out_valid), 512'(1));
        checkOutput("one_two_shift", 512'(bus.align_shift[4:0]), 512'(1));
        checkOutput("one_two_exp", 512'(bus.exponent_larger[7:0]), 512'(128));
        checkOutput("one_two_sig1", 512'(bus.significand1[25:0]), 512'(26'h0800000));
        checkOutput("one_two_sig2", 512'(bus.significand2[25:0]), 512'(26'h0800000));

        applyStimulus({4{32'h3F800000}}, {4{32'h3F800000}}, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        checkOutput("sub_equal_shift", 512'(bus.align_shift[4:0]), 512'(0));
        checkOutput("sub_equal_sig1", 512'(bus.significand1[25:0]), 512'(26'h0800000));
        checkOutput("sub_equal_sig2", 512'(bus.significand2[25:0]), 512'(26'h3800000));

        applyStimulus({4{32'h7F800000}}, {4{32'h7F800000}}, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        checkOutput("inf_minus_inf_nan", 512'(bus.result_is_nan[0]), 512'(1));
        checkOutput("inf_minus_inf_inf", 512'(bus.result_is_inf[0]), 512'(0));

        applyStimulus({4{32'h7F800000}}, {4{32'h3F800000}}, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        checkOutput("inf_plus_one_inf", 512'(bus.result_is_inf[0]), 512'(1));
        checkOutput("inf_plus_one_sign", 512'(bus.result_inf_sign[0]), 512'(0));

        applyStimulus({4{32'h3F800000}}, {4{32'h7F800000}}, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        checkOutput("one_minus_inf_sign", 512'(bus.result_inf_sign[0]), 512'(1));

        applyStimulus({4{32'h7F000000}}, {4{32'h00000001}}, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        checkOutput("saturate_shift", 512'(bus.align_shift[4:0]), 512'(26));
        checkOutput("subnormal_sig2", 512'(bus.significand2[25:0]), 512'(26'h0000001));

        applyStimulus({4{32'h3F800000}}, {4{32'hC0800000}}, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        checkOutput("swap_neg_sig1", 512'(bus.significand1[25:0]), 512'(26'h3800000));
        checkOutput("swap_neg_shift", 512'(bus.align_shift[4:0]), 512'(2));
        checkOutput("swap_neg_exp", 512'(bus.exponent_larger[7:0]), 512'(129));
        @(posedge clk);
        #1;

        // Stall the output, fill both registers, then release.
        opA = {randOp(), randOp(), randOp(), randOp()};
        opB = {randOp(), randOp(), randOp(), randOp()};
        opC = {randOp(), randOp(), randOp(), randOp()};
        bus.out_ready = 1'b0;
        applyStimulus(opA, opB, 1'b0, 1'b0);
        applyStimulus(opB, opC, 1'b1, 1'b0);
        bus.operand1 = opC;
        bus.operand2 = opA;
        checkOutput("stall_in_ready", 512'(bus.in_ready), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stall_still_full", 512'(bus.in_ready), 512'(0));
        checkOutput("stall_hold_data", 512'(observed()), 512'(model(opA, opB, 1'b0)));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", 512'(bus.in_ready), 512'(1));
        applyStimulus(opC, opA, 1'b0, 1'b0);
        bus.in_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            applyStimulus({randOp(), randOp(), randOp(), randOp()},
                          {randOp(), randOp(), randOp(), randOp()}, 1'($urandom_range(0, 1)), 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        checkOutput("random_drained", 512'(exp_q.size()), 512'(0));

        // Reset while both registers are occupied, with an input offered throughout.
        bus.out_ready = 1'b0;
        applyStimulus(opB, opA, 1'b0, 1'b0);
        applyStimulus(opC, opB, 1'b1, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        checkOutput("midstall_reset_valid", 512'(bus.out_valid), 512'(0));
        checkOutput("midstall_reset_ready", 512'(bus.in_ready), 512'(1));
        checkOutput("midstall_reset_data", 512'(observed()), 512'(0));
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("post_reset_idle", 512'(bus.out_valid), 512'(0));

        applyStimulus(opA, opC, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        checkOutput("post_reset_valid", 512'(bus.out_valid), 512'(1));
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        checkOutput("final_drained", 512'(exp_q.size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
